// File: rtl/dcache_controller.sv
// Data cache controller for the 2-way, 16-set, 32-byte-line dcache.
// Sequences hits, dirty write-back and refill between CPU, tag/data SRAM and memory.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {StIdle, StMiss, StWriteback, StRefill, StRefillDone} state_e;

  state_e         state_q, state_d;
  logic [22:0]    req_tag_q, req_tag_d;
  logic [3:0]     req_idx_q, req_idx_d;
  logic           mem_enable_q, mem_enable_d;
  logic           mem_write_q, mem_write_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [255:0]   mem_data_q, mem_data_d;

  logic        req;
  logic        store;
  logic [22:0] cpu_tag;
  logic [3:0]  cpu_idx;
  logic [7:0]  word_base;
  logic        unused_byte;

  assign req         = cpu_MemRead_i | cpu_MemWrite_i;
  assign store       = cpu_MemWrite_i & ~cpu_MemRead_i;
  assign cpu_tag     = cpu_addr_i[31:9];
  assign cpu_idx     = cpu_addr_i[8:5];
  assign word_base   = {cpu_addr_i[4:2], 5'b0};
  assign unused_byte = ^cpu_addr_i[1:0];

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign cpu_stall_o  = req & ~((state_q == StIdle) & sram_hit_i);

  always_comb begin
    state_d      = state_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    unique case (state_q)
      StIdle: begin
        // Latch the missing address so the refill survives a dropped request.
        if (req && !sram_hit_i) begin
          state_d   = StMiss;
          req_tag_d = cpu_tag;
          req_idx_d = cpu_idx;
        end
      end
      StMiss: begin
        mem_enable_d = 1'b1;
        if (sram_tag_i[24] && sram_tag_i[23]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {sram_tag_i[22:0], req_idx_q, 5'b0};
          mem_data_d  = sram_data_i;
          state_d     = StWriteback;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag_q, req_idx_q, 5'b0};
          state_d     = StRefill;
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag_q, req_idx_q, 5'b0};
          state_d     = StRefill;
        end
      end
      StRefill: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b0;
          state_d      = StRefillDone;
        end
      end
      StRefillDone: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_data_o    = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    if (cpu_MemRead_i) begin
      cpu_data_o = sram_data_i[word_base +: 32];
    end
    if (state_q == StIdle) begin
      if (req) begin
        sram_enable_o = 1'b1;
        sram_addr_o   = cpu_idx;
        sram_tag_o    = {1'b1, store, cpu_tag};
        if (sram_hit_i && store) begin
          sram_write_o                  = 1'b1;
          sram_data_o                   = sram_data_i;
          sram_data_o[word_base +: 32]  = cpu_data_i;
        end
      end
    end else begin
      // The victim tag is read in MISS even if the CPU dropped its request.
      sram_enable_o = req | (state_q == StMiss);
      sram_addr_o   = req_idx_q;
      sram_tag_o    = {1'b1, store, req_tag_q};
      if (state_q == StRefill && mem_ack_i) begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_data_o   = mem_data_i;
        sram_tag_o    = {2'b10, req_tag_q};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: SRAM and memory models, architectural reference memory,
// scoreboard of expected CPU responses checked by a completion monitor.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack = 1'b0;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural memory (reference) and off-chip memory contents, word addressed.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] mem_words [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    logic [255:0] l;
    int unsigned base;
    base = int'({a[31:5], 3'b0});
    for (int k = 0; k < 8; k++) begin
      l[32*k +: 32] = ref_mem.exists(base + k) ? ref_mem[base + k] : init_word(base + k);
    end
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    int unsigned base;
    base = int'({a[31:5], 3'b0});
    for (int k = 0; k < 8; k++) begin
      l[32*k +: 32] = mem_words.exists(base + k) ? mem_words[base + k] : init_word(base + k);
    end
    return l;
  endfunction

  // SRAM model: 2 ways, LRU victim on miss.
  logic [24:0]  s_tag  [2][16];
  logic [255:0] s_data [2][16];
  logic         s_lru  [16];
  logic         h0, h1, s_way;

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 16; s++) begin
        s_tag[w][s]  = '0;
        s_data[w][s] = '0;
      end
    end
    for (int s = 0; s < 16; s++) s_lru[s] = 1'b0;
  end

  always_comb begin
    h0 = s_tag[0][sram_addr_o][24] && (s_tag[0][sram_addr_o][22:0] == sram_tag_o[22:0]);
    h1 = s_tag[1][sram_addr_o][24] && (s_tag[1][sram_addr_o][22:0] == sram_tag_o[22:0]);
    sram_hit_i  = sram_enable_o && (h0 || h1);
    s_way       = h0 ? 1'b0 : (h1 ? 1'b1 : s_lru[sram_addr_o]);
    sram_tag_i  = s_tag[s_way][sram_addr_o];
    sram_data_i = s_data[s_way][sram_addr_o];
  end

  always @(posedge clk) begin
    if (sram_enable_o) begin
      if (sram_write_o) begin
        s_tag[s_way][sram_addr_o]  <= sram_tag_o;
        s_data[s_way][sram_addr_o] <= sram_data_o;
        s_lru[sram_addr_o]         <= ~s_way;
      end else if (sram_hit_i) begin
        s_lru[sram_addr_o] <= ~s_way;
      end
    end
  end

  // Memory model: random ack delay, spurious acks while idle, transaction log.
  logic [31:0] cur_addr = '0;
  bit          hold_rd = 1'b0;
  int          last_ack_cyc = 0;
  logic [32:0] mlog [$];

  initial begin
    int dly;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst) continue;
      if (mem_enable_o) begin
        if (dly > 0) begin
          dly--;
        end else if (!(hold_rd && !mem_write_o)) begin
          mem_ack = 1'b1;
          last_ack_cyc = cyc;
          mlog.push_back({mem_write_o, mem_addr_o});
          if (mem_write_o) begin
            chk("wb_addr_set", {mem_addr_o[8:0]}, {cur_addr[8:5], 5'b0});
            chk("wb_data", mem_data_o, ref_line(mem_addr_o));
            for (int k = 0; k < 8; k++) begin
              mem_words[int'({mem_addr_o[31:5], 3'b0}) + k] = mem_data_o[32*k +: 32];
            end
          end else begin
            chk("rd_addr", mem_addr_o, {cur_addr[31:5], 5'b0});
            mem_data_i = mem_line(mem_addr_o);
          end
          dly = $urandom_range(0, 3);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
        mem_data_i = {8{$urandom}};
      end
    end
  end

  // Scoreboard: expected response pushed at issue, popped on completion.
  typedef struct {
    bit           w;
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [255:0] line;
  } exp_t;
  exp_t sb [$];
  exp_t me;

  always @(negedge clk) begin
    if (!rst && (rd || wr) && !cpu_stall_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got completion expected none (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        if (!me.w) begin
          chk("load_data", cpu_data_o, me.data);
        end else begin
          chk("store_write", sram_write_o, 1'b1);
          chk("store_tag", sram_tag_o, {2'b11, me.addr[31:9]});
          chk("store_line", sram_data_o, me.line);
          ref_mem[int'(me.addr[31:2])] = me.data;
        end
      end
    end
    if (!rst && sram_write_o && cpu_stall_o) begin
      chk("refill_tag", sram_tag_o, {2'b10, cur_addr[31:9]});
      chk("refill_line", sram_data_o, ref_line(cur_addr));
    end
  end

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  bit first_stall;
  int last_done_cyc;

  // Called at posedge+1; returns at posedge+1 after completion.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    exp_t e;
    bit   done;
    int   start;
    logic [255:0] l;
    e.w = w;
    e.addr = a;
    e.data = w ? d : ref_line(a)[32*a[4:2] +: 32];
    l = ref_line(a);
    l[32*a[4:2] +: 32] = d;
    e.line = l;
    sb.push_back(e);
    cur_addr = a;
    cpu_addr = a;
    cpu_wdata = w ? d : $urandom;
    rd = !w;
    wr = w;
    start = cyc;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 0) first_stall = cpu_stall_o;
      if (!cpu_stall_o) begin
        done = 1'b1;
        break;
      end
    end
    lat = cyc - start;
    last_done_cyc = cyc;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got stall after 80 cycles expected completion addr %0h", a);
      finish_run();
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    int lat;
    bit found;
    logic [31:0] a;
    ref_mem[16] = 32'hDEADBEEF;
    ref_mem[18] = 32'hDEADBEEF;
    mem_words[16] = 32'hDEADBEEF;
    mem_words[18] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_mem_en", mem_enable_o, 1'b0);
    chk("rst_mem_wr", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 256'h0);
    chk("rst_sram_en", sram_enable_o, 1'b0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    @(posedge clk);
    #1;

    // Cold load miss.
    mlog.delete();
    do_req(1'b0, 32'h40, 32'h0, lat);
    chk("cold_stall", first_stall, 1'b1);
    chk("cold_ack_to_done", last_done_cyc - last_ack_cyc, 2);
    chk("cold_log_n", mlog.size(), 1);
    chk("cold_log0", mlog[0], {1'b0, 32'h40});

    // Repeat load hit, then store hit.
    mlog.delete();
    do_req(1'b0, 32'h40, 32'h0, lat);
    chk("hit_load_lat", lat, 0);
    do_req(1'b1, 32'h44, 32'h12345678, lat);
    chk("hit_store_lat", lat, 0);
    chk("hit_log_n", mlog.size(), 0);

    // Store miss to clean (empty) victim in set 2.
    mlog.delete();
    do_req(1'b1, 32'h248, 32'hCAFEF00D, lat);
    chk("smiss_log_n", mlog.size(), 1);
    chk("smiss_log0", mlog[0], {1'b0, 32'h240});

    // Both ways of set 2 dirty: third tag forces write-back of the LRU line.
    mlog.delete();
    do_req(1'b0, 32'h440, 32'h0, lat);
    chk("dmiss_log_n", mlog.size(), 2);
    chk("dmiss_log0", mlog[0], {1'b1, 32'h40});
    chk("dmiss_log1", mlog[1], {1'b0, 32'h440});

    // Reset while the refill read is outstanding.
    mlog.delete();
    hold_rd = 1'b1;
    cur_addr = 32'h640;
    cpu_addr = 32'h640;
    rd = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_enable_o && !mem_write_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("rmid_reach_refill", found, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd = 1'b0;
    @(negedge clk);
    chk("rmid_no_sram_wr", sram_write_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_mem_en", mem_enable_o, 1'b0);
    chk("rmid_stall", cpu_stall_o, 1'b0);
    chk("rmid_log_n", mlog.size(), 1);
    chk("rmid_log0", mlog[0], {1'b1, 32'h240});
    hold_rd = 1'b0;
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h640, 32'h0, lat);

    // Random traffic over a few tags in three sets to force evictions.
    for (int n = 0; n < 400; n++) begin
      a = {23'($urandom_range(0, 4)), 4'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 2'b0};
      do_req($urandom_range(0, 9) < 4, a, $urandom, lat);
    end

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    finish_run();
  end

endmodule
